sequence_player: RTL
====================

SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum steps played per run.
REQ-002 SHALL have parameter ON_TICKS, default 8, base LED-on duration in tick strobes.
REQ-003 SHALL have parameter GAP_TICKS, default 2, dark gap between steps in tick strobes.
REQ-004 SHALL have port clk  input  1  system clock; sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  one-cycle timing strobe from the clock divider (nominal 10 Hz).
REQ-007 SHALL have port start  input  1  one-cycle request to play a sequence.
REQ-008 SHALL have port length  input  4  number of steps to play.
REQ-009 SHALL have port speed  input  2  speed level (0 slowest .. 3 fastest).
REQ-010 SHALL have port step_idx  output  3  pattern-memory read address.
REQ-011 SHALL have port step_data  input  4  LED index at step_idx; combinational read, valid the same cycle.
REQ-012 SHALL have port leds  output  16  one-hot display pattern, registered.
REQ-013 SHALL have port busy  output  1  high from the cycle after an accepted start until the DONE state.
REQ-014 SHALL have port done  output  1  one-cycle pulse when playback completes.

Function
REQ-015 SHALL implement states IDLE, LOAD, ON, GAP, DONE.
REQ-016 IDLE: start=1 SHALL latch eff_len = min(length, MAX_LEN) and the speed level, clear step_idx, and go to LOAD.
REQ-017 start asserted outside IDLE SHALL be ignored; length and speed changes mid-run SHALL have no effect.
REQ-018 eff_len = 0 SHALL go from IDLE directly to DONE, with leds remaining 0.
REQ-019 LOAD SHALL register leds = 1 << step_data, clear the tick counter, and go to ON in one cycle.
REQ-020 ON duration SHALL be max(1, ON_TICKS >> speed) tick strobes, counting only tick cycles.
REQ-021 On expiry of the ON duration, the design SHALL clear leds the same edge and enter GAP.
REQ-022 In GAP, after GAP_TICKS strobes, the design SHALL go to LOAD with step_idx+1 if steps remain, else to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-024 Latency: start accepted at edge N -> busy=1 after N; first LED visible after N+1.
REQ-025 step_idx SHALL never exceed eff_len-1; no wrap-around.
REQ-026 A tick coinciding with the LOAD cycle SHALL NOT be counted.

Reset
REQ-027 On reset the design SHALL set state IDLE, leds=0, busy=0, done=0, step_idx=0, and counters 0.
REQ-028 Reset mid-run SHALL abort playback with no done pulse; reset SHALL take priority over start.

Configuration
REQ-029 With SEQ_PLAYER_GAP_EN defined, GAP SHALL behave per REQ-022.
REQ-030 Without SEQ_PLAYER_GAP_EN, the ON state SHALL go directly to LOAD/DONE, GAP_TICKS SHALL be unused, and leds SHALL change step-to-step without a dark cycle except LOAD.

Structure
REQ-031 The state enum and the speed-shift constants SHALL reside in shared package simon_pkg.
REQ-032 The tick-duration counter SHALL be sub-module tick_timer (load value, count on tick, expire flag).

Verification
REQ-033 Test 1: reset, then start with length=3, speed=0, pattern {5,0,15}, tick every 4 clk -> leds 0x0020, 0x0001, 0x8000, each on for 8 ticks with 2-tick gaps, then a single done pulse.
REQ-034 Test 2: length=12 -> exactly 8 steps played (step_idx 0..7), then done.
REQ-035 Test 3: length=0 -> done pulse within 2 cycles of start, leds stay 0.
REQ-036 Test 4: speed=3 with ON_TICKS=8 -> each LED on for 1 tick; speed=2 -> 2 ticks.
REQ-037 Test 5: second start pulse mid-run, plus reset asserted during ON of step 1 -> the second start is ignored; after reset leds=0, busy=0, and no done pulse occurs.
REQ-038 Test 6: build without SEQ_PLAYER_GAP_EN -> consecutive steps separated only by the one-cycle LOAD.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_pkg : shared FSM states and speed-shift constants             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ON   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int c_TMR_W = 8;
  localparam int c_SPEED_SHIFT [4] = '{0, 1, 2, 3};

  // Faster speeds shorten the on-time, but never below one tick.
  function automatic logic [c_TMR_W-1:0] on_duration(input int base, input logic [1:0] spd);
    int d;
    d = base >> c_SPEED_SHIFT[spd];
    if (d < 1) d = 1;
    return c_TMR_W'(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_timer : loadable down-counter of tick strobes with expire flag |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_timer
  import simon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [c_TMR_W-1:0] i_load_val,
  input  logic               i_en,
  input  logic               i_tick,
  output logic               o_expire
);

  logic [c_TMR_W-1:0] r_cnt;

  // Load wins over counting, so a tick on the load cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_TMR_W'(1);
    end
  end

  assign o_expire = i_en && i_tick && (r_cnt == c_TMR_W'(1));

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sequence_player : plays a stored LED pattern, timed by tick strobes |
// | Option macro: SEQ_PLAYER_GAP_EN (dark gap between steps). Rev 1.0   |
// +--------------------------------------------------------------------+
module sequence_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN   = 8,
  parameter int ON_TICKS  = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  length,
  input  logic [1:0]  speed,
  output logic [2:0]  step_idx,
  input  logic [3:0]  step_data,
  output logic [15:0] leds,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0]         c_MAX_LEN = 4'(MAX_LEN);
  localparam logic [c_TMR_W-1:0] c_GAP_VAL = c_TMR_W'((GAP_TICKS < 1) ? 1 : GAP_TICKS);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_len;
  logic [1:0]          r_speed;
  logic [2:0]          r_step_idx;
  logic [15:0]         r_leds;
  logic [3:0]          w_eff_len;
  logic                w_last;
  logic                w_tmr_load;
  logic [c_TMR_W-1:0]  w_tmr_val;
  logic                w_tmr_en;
  logic                w_expire;

  assign w_eff_len = (length > c_MAX_LEN) ? c_MAX_LEN : length;
  assign w_last    = ({1'b0, r_step_idx} == (r_len - 4'd1));

`ifndef SEQ_PLAYER_GAP_EN
  logic w_unused_gap;
  assign w_unused_gap = ^c_GAP_VAL;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = on_duration(ON_TICKS, r_speed);
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = (w_eff_len == 4'd0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        w_tmr_load = 1'b1;
        w_next     = ST_ON;
      end
      ST_ON: begin
        w_tmr_en = 1'b1;
        if (w_expire) begin
`ifdef SEQ_PLAYER_GAP_EN
          w_tmr_load = 1'b1;
          w_tmr_val  = c_GAP_VAL;
          w_next     = ST_GAP;
`else
          w_next     = w_last ? ST_DONE : ST_LOAD;
`endif
        end
      end
      ST_GAP: begin
        w_tmr_en = 1'b1;
        if (w_expire) w_next = w_last ? ST_DONE : ST_LOAD;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Run parameters are captured once at start so mid-run input changes are inert.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= 4'd0;
      r_speed    <= 2'd0;
      r_step_idx <= 3'd0;
      r_leds     <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len      <= w_eff_len;
            r_speed    <= speed;
            r_step_idx <= 3'd0;
          end
        end
        ST_LOAD: r_leds <= 16'd1 << step_data;
        ST_ON: begin
          if (w_expire) begin
            r_leds <= 16'd0;
`ifndef SEQ_PLAYER_GAP_EN
            if (!w_last) r_step_idx <= r_step_idx + 3'd1;
`endif
          end
        end
        ST_GAP: begin
          if (w_expire && !w_last) r_step_idx <= r_step_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  tick_timer u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .i_tick     (tick),
    .o_expire   (w_expire)
  );

  assign step_idx = r_step_idx;
  assign leds     = r_leds;
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_ON) || (r_state == ST_GAP);
  assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire
